// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage registers.
// The state type covers both the single-entry and skid (PIPE_SKID_EN) builds.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Bit positions inside the control bundle carried between stages.
    localparam int unsigned CTRL_MEMTOREG = 0;
    localparam int unsigned CTRL_REGWRITE = 1;
    localparam int unsigned CTRL_MEMREAD  = 2;
    localparam int unsigned CTRL_MEMWRITE = 3;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with flush-to-bubble and a stall counter.
// Define PIPE_SKID_EN for a two-entry skid version with a registered in_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 69,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              consume;

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // ctrl_q is cleared whenever the main slot empties, so it is already zero in bubbles.
    assign out_ctrl = ctrl_q;
    assign out_data = data_q;

`ifdef PIPE_SKID_EN
    logic              in_ready_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    assign in_ready = in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            ctrl_q      <= '0;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            ctrl_q      <= '0;
            skid_ctrl_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        ctrl_q  <= in_ctrl;
                        data_q  <= in_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        ctrl_q <= in_ctrl;
                        data_q <= in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the newcomer behind the main entry.
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                        state_q     <= FULL;
                        in_ready_q  <= 1'b0;
                    end else if (consume) begin
                        ctrl_q  <= '0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        ctrl_q      <= skid_ctrl_q;
                        data_q      <= skid_data_q;
                        skid_ctrl_q <= '0;
                        state_q     <= ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    ctrl_q  <= '0;
                    state_q <= EMPTY;
                end
            endcase
        end
    end
`else
    // Single entry: a consume this cycle frees the slot, hence the out_ready -> in_ready path.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
        end else if (accept) begin
            ctrl_q  <= in_ctrl;
            data_q  <= in_data;
            state_q <= ONE;
        end else if (consume) begin
            ctrl_q  <= '0;
            state_q <= EMPTY;
        end
    end
`endif

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against a queue scoreboard.
// Works for both the default build and PIPE_SKID_EN.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned DATA_W = 69;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    entry_t            sb_q[$];
    logic [CNT_W-1:0]  model_cnt;
    logic              checks_on = 1'b0;
    int                errors    = 0;
    int                checks    = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs mid-cycle, then advance the scoreboard by one clock.
    task automatic tick();
        logic exp_valid;
        logic exp_ready;
        entry_t head;
        @(negedge clk);
        exp_valid = (sb_q.size() != 0);
`ifdef PIPE_SKID_EN
        exp_ready = (sb_q.size() < 2);
`else
        exp_ready = !exp_valid || out_ready;
`endif
        if (checks_on) begin
            check("out_valid", out_valid, exp_valid);
            check("in_ready", in_ready, exp_ready);
            check("stall_cnt", stall_cnt, model_cnt);
            if (exp_valid) begin
                head = sb_q[0];
                check("out_data", out_data, head.data);
                check("out_ctrl", out_ctrl, head.ctrl);
            end else begin
                check("out_ctrl_bubble", out_ctrl, 0);
            end
        end
        if (rst) begin
            sb_q.delete();
            model_cnt = '0;
            checks_on = 1'b1;
        end else begin
            if (exp_valid && !out_ready && (model_cnt != '1)) model_cnt = model_cnt + 1'b1;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (exp_valid && out_ready) void'(sb_q.pop_front());
                if (in_valid && exp_ready) sb_q.push_back({in_ctrl, in_data});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = '0;
        out_ready = 1'b0;
        model_cnt = '0;

        // 1: reset with an input being offered
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // 2: streaming with downstream always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CTRL_W'(i);
            in_data  = DATA_W'(i);
            tick();
            check("stream_data", out_data, DATA_W'(i));
        end
        in_valid = 1'b0;
        tick();
        tick();

        // 3: back-pressure, A/B/C offered while downstream stalls
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h1;
        in_data   = 69'hA;
        tick();
        in_data = 69'hB;
        tick();
`ifdef PIPE_SKID_EN
        check("bp_in_ready_full", in_ready, 0);
        in_data = 69'hC;
        tick();
        tick();
        check("bp_stall_cnt", stall_cnt, 3);
        check("bp_head_a", out_data, 69'hA);
`else
        check("bp_in_ready_one", in_ready, 0);
        tick();
        check("bp_stall_cnt", stall_cnt, 2);
        check("bp_head_a", out_data, 69'hA);
        in_data = 69'hC;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();

        // 4: flush while occupied; the flush-cycle input must vanish
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h8;
        in_data   = 69'h11;
        tick();
        in_data = 69'h22;
        tick();
        flush   = 1'b1;
        in_ctrl = 4'b0010;
        in_data = 69'h33;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_ctrl", out_ctrl, 0);
        check("flush_regwrite", out_ctrl[CTRL_REGWRITE], 0);
        check("flush_state", dut.state_q, EMPTY);
        tick();

        // 5: stall counter saturation
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 69'h55;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt", stall_cnt, 15);
        tick();
        check("sat_hold", stall_cnt, 15);
        out_ready = 1'b1;
        tick();

        // 6: random traffic with occasional flush and reset
        for (int i = 0; i < 10000; i++) begin
            rst       = ($urandom_range(0, 999) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_ctrl   = CTRL_W'($urandom_range(0, 15));
            in_data   = {$urandom(), $urandom(), $urandom()};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
